// File: rtl/score_accumulator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// score_accumulator
//
// Game-score engine between the hit-detect logic and the score display drawer.
// Rising edges on each hit-event line add that source's point weight, a rising
// edge on the penalty line removes penalty_pts, and the result is clamped to
// 0..SCORE_MAX. The binary score is converted serially (double-dabble) to BCD
// for the HUD / 7-segment path.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   clear          synchronous score clear (new game), level sensitive
//   event_in       hit levels, one per point source
//   penalty_in     penalty hit level
//   penalty_pts    points removed per penalty edge
//   score          binary score
//   score_bcd      BCD score, digit 0 ([3:0]) = units
//   bcd_valid      score_bcd matches score
//   score_changed  one-cycle pulse after the score register changed value
//   saturated      score == SCORE_MAX
//   armed          events are being counted
//
// BCD converter states
//   state | meaning
//   IDLE  | score_bcd up to date, waiting for a score change
//   LOAD  | capture the current score into the shift register
//   SHIFT | SCORE_W add-3-then-shift iterations
//   DONE  | publish result, or restart if the score moved meanwhile
// -----------------------------------------------------------------------------
module score_accumulator #(
    parameter int                        NUM_SRC    = 4,
    parameter int                        PTS_W      = 4,
    parameter logic [NUM_SRC*PTS_W-1:0]  SRC_POINTS = {4'd8, 4'd4, 4'd2, 4'd1},
    parameter int                        SCORE_W    = 14,
    parameter int                        SCORE_MAX  = 9999,
    parameter int                        DIGITS     = 4,
    parameter int                        ARM_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [NUM_SRC-1:0]    event_in,
    input  logic                  penalty_in,
    input  logic [PTS_W-1:0]      penalty_pts,
    output logic [SCORE_W-1:0]    score,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  bcd_valid,
    output logic                  score_changed,
    output logic                  saturated,
    output logic                  armed
);

    // Wide enough that score + all weights - penalty never wraps; MSB is sign.
    localparam int NEXT_W = SCORE_W + PTS_W + $clog2(NUM_SRC) + 1;
    localparam int ARM_W  = (ARM_CYCLES < 1) ? 1 : $clog2(ARM_CYCLES + 1);
    localparam int CNT_W  = $clog2(SCORE_W + 1);
    localparam int SH_W   = 4*DIGITS + SCORE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } bcdState_t;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] prevEvt;
    logic               prevPen;
    logic [NUM_SRC-1:0] evtRise;
    logic               penRise;

    // Edge registers follow the inputs even in reset, so a level held
    // through reset release never looks like a fresh hit.
    always_ff @(posedge clk) begin
        prevEvt <= event_in;
        prevPen <= penalty_in;
    end

    assign evtRise = event_in & ~prevEvt;
    assign penRise = penalty_in & ~prevPen;

    // ------------------------------------------------------------------
    // Arming
    // ------------------------------------------------------------------
    logic [ARM_W-1:0] armCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            armCnt <= '0;
            armed  <= 1'b0;
        end else if (!armed) begin
            armCnt <= armCnt + ARM_W'(1);
            armed  <= (({1'b0, armCnt} + (ARM_W+1)'(1)) >= (ARM_W+1)'(ARM_CYCLES));
        end
    end

    // ------------------------------------------------------------------
    // Score arithmetic
    // ------------------------------------------------------------------
    logic [NEXT_W-1:0]  addSum;
    logic [NEXT_W-1:0]  subVal;
    logic [NEXT_W-1:0]  nextRaw;
    logic [SCORE_W-1:0] nextClamped;
    logic               scoreWillChange;

    always_comb begin
        addSum = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (evtRise[i]) begin
                addSum = addSum + NEXT_W'(SRC_POINTS[i*PTS_W +: PTS_W]);
            end
        end
        subVal  = penRise ? NEXT_W'(penalty_pts) : '0;
        nextRaw = NEXT_W'(score) + addSum - subVal;

        if (nextRaw[NEXT_W-1]) begin
            nextClamped = '0;
        end else if (nextRaw > NEXT_W'(SCORE_MAX)) begin
            nextClamped = SCORE_W'(SCORE_MAX);
        end else begin
            nextClamped = nextRaw[SCORE_W-1:0];
        end
    end

    always_comb begin
        scoreWillChange = 1'b0;
        if (clear) begin
            scoreWillChange = (score != '0);
        end else if (armed) begin
            scoreWillChange = (nextClamped != score);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score         <= '0;
            score_changed <= 1'b0;
        end else if (clear) begin
            score         <= '0;
            score_changed <= scoreWillChange;
        end else if (armed) begin
            score         <= nextClamped;
            score_changed <= scoreWillChange;
        end else begin
            score_changed <= 1'b0;
        end
    end

    assign saturated = (score == SCORE_W'(SCORE_MAX));

    // ------------------------------------------------------------------
    // BCD converter
    // ------------------------------------------------------------------
    bcdState_t           state;
    bcdState_t           nextState;
    logic                pending;
    logic [SCORE_W-1:0]  binSh;
    logic [4*DIGITS-1:0] bcdSh;
    logic [CNT_W-1:0]    bitCnt;
    logic [SH_W-1:0]     shiftNext;
    logic                loadEn;
    logic                shiftEn;
    logic                writeEn;
    logic                restart;

    function automatic logic [4*DIGITS-1:0] dabble(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (r[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = r[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign shiftNext = {dabble(bcdSh), binSh} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        loadEn    = 1'b0;
        shiftEn   = 1'b0;
        writeEn   = 1'b0;
        // A change seen while sitting in DONE is as stale as a pending one.
        restart   = pending | score_changed;
        case (state)
            IDLE: begin
                if (score_changed) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                loadEn    = 1'b1;
                nextState = SHIFT;
            end
            SHIFT: begin
                shiftEn = 1'b1;
                if (bitCnt == CNT_W'(1)) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (restart) begin
                    nextState = LOAD;
                end else begin
                    writeEn   = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_bcd <= '0;
            bcd_valid <= 1'b1;
            pending   <= 1'b0;
            binSh     <= '0;
            bcdSh     <= '0;
            bitCnt    <= '0;
        end else begin
            // Invalidate on the same edge the score moves, so bcd_valid never
            // claims a match against the new value.
            if (scoreWillChange) begin
                bcd_valid <= 1'b0;
            end else if (writeEn) begin
                bcd_valid <= 1'b1;
            end

            if (writeEn) begin
                score_bcd <= bcdSh;
            end

            if (state == DONE) begin
                pending <= 1'b0;
            end else if (score_changed && (state != IDLE)) begin
                pending <= 1'b1;
            end

            if (loadEn) begin
                binSh  <= score;
                bcdSh  <= '0;
                bitCnt <= CNT_W'(SCORE_W);
            end else if (shiftEn) begin
                bcdSh  <= shiftNext[SH_W-1:SCORE_W];
                binSh  <= shiftNext[SCORE_W-1:0];
                bitCnt <= bitCnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_score_accumulator.sv
`timescale 1ns/1ps
module tb_score_accumulator;

    localparam int SCORE_MAX = 9999;
    localparam int ARM_CYC   = 2;
    localparam int BCD_BOUND = 34;
    localparam int PACKED    = 'h8421;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [3:0]  event_in;
    logic        penalty_in;
    logic [3:0]  penalty_pts;
    logic [13:0] score;
    logic [15:0] score_bcd;
    logic        bcd_valid;
    logic        score_changed;
    logic        saturated;
    logic        armed;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         mScore;
    logic [3:0] mPrevEvt;
    logic       mPrevPen;
    int         mSince;
    bit         mArmed;
    bit         mChanged;
    int         sinceChange;
    bit         justReset;

    score_accumulator #(
        .NUM_SRC   (4),
        .PTS_W     (4),
        .SRC_POINTS(16'h8421),
        .SCORE_W   (14),
        .SCORE_MAX (SCORE_MAX),
        .DIGITS    (4),
        .ARM_CYCLES(ARM_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .event_in     (event_in),
        .penalty_in   (penalty_in),
        .penalty_pts  (penalty_pts),
        .score        (score),
        .score_bcd    (score_bcd),
        .bcd_valid    (bcd_valid),
        .score_changed(score_changed),
        .saturated    (saturated),
        .armed        (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int weight(input int i);
        return (PACKED >> (4*i)) % 16;
    endfunction

    function automatic logic [31:0] toBcd(input int v);
        logic [31:0] r;
        r = 0;
        for (int d = 0; d < 4; d++) begin
            r = r | (32'((v / (10**d)) % 10) << (4*d));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge();
        int n;
        int old;
        logic [3:0] rises;
        logic penR;
        if (reset) begin
            mScore      = 0;
            mChanged    = 0;
            mArmed      = 0;
            mSince      = 0;
            sinceChange = 1000;
            justReset   = 1;
        end else begin
            justReset = 0;
            rises = event_in & ~mPrevEvt;
            penR  = penalty_in & ~mPrevPen;
            old   = mScore;
            if (clear) begin
                mScore = 0;
            end else if (mArmed) begin
                n = mScore;
                for (int i = 0; i < 4; i++) if (rises[i]) n += weight(i);
                if (penR) n -= int'(penalty_pts);
                if (n < 0) n = 0;
                if (n > SCORE_MAX) n = SCORE_MAX;
                mScore = n;
            end
            mChanged = (mScore != old);
            mSince++;
            mArmed = (mSince >= ARM_CYC);
            if (mChanged) sinceChange = 0;
            else if (sinceChange < 1000) sinceChange++;
        end
        mPrevEvt = event_in;
        mPrevPen = penalty_in;
    endtask

    task automatic checkAll();
        chk("score", 32'(score), 32'(mScore));
        chk("score_changed", 32'(score_changed), 32'(mChanged));
        chk("saturated", 32'(saturated), 32'(mScore == SCORE_MAX));
        chk("armed", 32'(armed), 32'(mArmed));
        if (justReset) begin
            chk("rst_bcd_valid", 32'(bcd_valid), 32'd1);
            chk("rst_score_bcd", 32'(score_bcd), 32'd0);
        end else if (mChanged) begin
            chk("bcd_valid_drop", 32'(bcd_valid), 32'd0);
        end else if (sinceChange >= BCD_BOUND) begin
            chk("bcd_timeout", 32'(bcd_valid), 32'd1);
        end
        if (bcd_valid === 1'b1) chk("score_bcd", 32'(score_bcd), toBcd(mScore));
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic drive(input logic [3:0] e, input logic p, input logic [3:0] pp, input logic c);
        event_in    = e;
        penalty_in  = p;
        penalty_pts = pp;
        clear       = c;
    endtask

    initial begin
        int waited;
        mPrevEvt = '0; mPrevPen = 1'b0; mScore = 0; mSince = 0;
        mArmed = 0; mChanged = 0; sinceChange = 1000; justReset = 0;

        // Reset with source 0 held high: the held level must never score.
        reset = 1'b1;
        drive(4'b0001, 1'b0, 4'd0, 1'b0);
        step(); step();
        chk("reset_score", 32'(score), 32'd0);
        chk("reset_armed", 32'(armed), 32'd0);
        reset = 1'b0;
        step();
        chk("arm_cycle1", 32'(armed), 32'd0);
        step();
        chk("arm_cycle2", 32'(armed), 32'd1);
        repeat (4) step();
        chk("held_level_no_score", 32'(score), 32'd0);

        // Single rise on source 2 (weight 4), then BCD within 17 cycles.
        drive(4'b0101, 1'b0, 4'd0, 1'b0);
        step();
        chk("single_rise_score", 32'(score), 32'd4);
        chk("single_rise_pulse", 32'(score_changed), 32'd1);
        step();
        chk("pulse_one_cycle", 32'(score_changed), 32'd0);
        repeat (16) step();
        chk("bcd_latency_valid", 32'(bcd_valid), 32'd1);
        chk("bcd_latency_value", 32'(score_bcd), 32'h0004);

        // Reach 10, then all sources plus a penalty of 5 in one cycle.
        drive(4'b0000, 1'b0, 4'd0, 1'b0); step();
        drive(4'b0110, 1'b0, 4'd0, 1'b0); step();
        chk("score_10", 32'(score), 32'd10);
        drive(4'b0000, 1'b0, 4'd0, 1'b0); step();
        drive(4'b1111, 1'b1, 4'd5, 1'b0); step();
        chk("multi_rise_penalty", 32'(score), 32'd20);
        drive(4'b0000, 1'b0, 4'd0, 1'b0); step();

        // Climb to 9995, then saturate.
        repeat (665) begin
            drive(4'b1111, 1'b0, 4'd0, 1'b0); step();
            drive(4'b0000, 1'b0, 4'd0, 1'b0); step();
        end
        chk("score_9995", 32'(score), 32'd9995);
        drive(4'b1000, 1'b0, 4'd0, 1'b0); step();
        chk("sat_score", 32'(score), 32'd9999);
        chk("sat_flag", 32'(saturated), 32'd1);
        drive(4'b0000, 1'b0, 4'd0, 1'b0); step();
        drive(4'b1000, 1'b0, 4'd0, 1'b0); step();
        chk("sat_hold_score", 32'(score), 32'd9999);
        chk("sat_no_pulse", 32'(score_changed), 32'd0);

        // Floor at zero, then clear beating a simultaneous event.
        drive(4'b0000, 1'b0, 4'd0, 1'b1); step();
        drive(4'b0011, 1'b0, 4'd0, 1'b0); step();
        chk("score_3", 32'(score), 32'd3);
        drive(4'b0000, 1'b0, 4'd0, 1'b0); step();
        drive(4'b0000, 1'b1, 4'd5, 1'b0); step();
        chk("floor_zero", 32'(score), 32'd0);
        drive(4'b0000, 1'b0, 4'd0, 1'b0); step();
        repeat (2) begin
            drive(4'b1111, 1'b0, 4'd0, 1'b0); step();
            drive(4'b0000, 1'b0, 4'd0, 1'b0); step();
        end
        drive(4'b1010, 1'b0, 4'd0, 1'b0); step();
        chk("score_40", 32'(score), 32'd40);
        drive(4'b0000, 1'b0, 4'd0, 1'b0); step();
        drive(4'b1111, 1'b0, 4'd0, 1'b1); step();
        chk("clear_beats_event", 32'(score), 32'd0);
        chk("clear_pulse", 32'(score_changed), 32'd1);
        chk("clear_keeps_armed", 32'(armed), 32'd1);
        drive(4'b0000, 1'b0, 4'd0, 1'b0);
        repeat (40) step();
        chk("settled_valid", 32'(bcd_valid), 32'd1);

        // Two changes three cycles apart: old BCD held until the final result.
        drive(4'b0001, 1'b0, 4'd0, 1'b0); step();
        drive(4'b0000, 1'b0, 4'd0, 1'b0); step();
        step();
        drive(4'b0100, 1'b0, 4'd0, 1'b0); step();
        chk("two_change_score", 32'(score), 32'd5);
        drive(4'b0000, 1'b0, 4'd0, 1'b0);
        waited = 0;
        while (bcd_valid !== 1'b1 && waited < 40) begin
            chk("two_change_hold", 32'(score_bcd), 32'd0);
            step();
            waited++;
        end
        chk("two_change_in_time", 32'(waited <= BCD_BOUND), 32'd1);
        chk("two_change_valid", 32'(bcd_valid), 32'd1);
        chk("two_change_bcd", 32'(score_bcd), toBcd(5));

        // Randomized traffic, including clears and mid-conversion resets.
        repeat (3000) begin
            reset = ($urandom_range(0, 799) == 0);
            drive(4'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom),
                  ($urandom_range(0, 99) == 0));
            step();
        end
        reset = 1'b0;
        drive(4'b0000, 1'b0, 4'd0, 1'b0);
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
